// File: rtl/roce_stack_req_translator.sv
// RDMA request -> datamover command translator with one-entry address cache.
// Latency: cached path 2 cycles to first command, lookup path adds translation round trip; backpressure holds registered outputs.
module roce_stack_req_translator #(
  parameter logic READ      = 1'b1,
  parameter int   ADDR_W    = 64,
  parameter int   LEN_W     = 28,
  parameter int   BTT_W     = 23,
  parameter int   MAX_CHUNK = 65536,
  parameter int   CMD_W     = ADDR_W + BTT_W + 17
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 s_rdma_req_valid_i,
  output logic                 s_rdma_req_ready_o,
  input  logic [ADDR_W-1:0]    s_rdma_req_vaddr_i,
  input  logic [LEN_W-1:0]     s_rdma_req_len_i,
  input  logic                 s_rdma_req_ctl_i,
  output logic                 req_addr_valid_o,
  input  logic                 req_addr_ready_i,
  output logic [ADDR_W-1:0]    req_addr_vaddr_o,
  input  logic                 resp_addr_valid_i,
  output logic                 resp_addr_ready_o,
  input  logic [ADDR_W+51:0]   resp_addr_data_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [CMD_W-1:0]     cmd_data_o,
  output logic                 err_valid_o,
  output logic [1:0]           err_code_o,
  output logic                 busy_o
);

  localparam int BW      = ((ADDR_W > 48) ? ADDR_W : 48) + 1;
  localparam int CW      = (LEN_W > BTT_W) ? LEN_W : BTT_W;
  localparam logic [CW-1:0] MC = CW'(MAX_CHUNK);
  localparam int ACC_BIT = ADDR_W + 48 + (READ ? 0 : 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_CHECK, S_SEND} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_vaddr;
  logic [LEN_W-1:0]    r_len;
  logic [ADDR_W-1:0]   r_base;
  logic                r_cache_vld;
  logic [ADDR_W-1:0]   r_paddr;
  logic [47:0]         r_buflen;
  logic                r_acc_ok;
  logic                r_req_vld;
  logic                r_cmd_vld;
  logic [CMD_W-1:0]    r_cmd_dat;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_rem;
  logic [BTT_W-1:0]    r_btt;
  logic [3:0]          r_tag;
  logic                r_err_vld;
  logic [1:0]          r_err_code;

  logic [ADDR_W-1:0]   w_offset;
  logic [BW-1:0]       w_end;
  logic                w_bounds_bad;
  logic [LEN_W-1:0]    w_next_rem;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [ADDR_W-1:0]   w_first_addr;

  function automatic logic [BTT_W-1:0] f_chunk(input logic [LEN_W-1:0] rem);
    logic [CW-1:0] ext;
    ext = CW'(rem);
    return (ext < MC) ? BTT_W'(ext) : BTT_W'(MC);
  endfunction

  function automatic logic f_last(input logic [LEN_W-1:0] rem);
    return CW'(rem) <= MC;
  endfunction

  function automatic logic [CMD_W-1:0] f_cmd(input logic [ADDR_W-1:0] addr,
                                             input logic [BTT_W-1:0]  btt,
                                             input logic              eof,
                                             input logic [3:0]        tag);
    return {4'b0, tag, addr, 1'b0, eof, 6'b0, 1'b1, btt};
  endfunction

  assign w_offset     = r_vaddr - r_base;
  assign w_end        = BW'(w_offset) + BW'(r_len);
  assign w_bounds_bad = (r_vaddr < r_base) || (w_end > BW'(r_buflen));
  assign w_next_rem   = r_rem - LEN_W'(r_btt);
  assign w_next_addr  = r_cur_addr + ADDR_W'(r_btt);
  assign w_first_addr = r_paddr + w_offset;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state     <= S_IDLE;
      r_vaddr     <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_cache_vld <= 1'b0;
      r_paddr     <= '0;
      r_buflen    <= '0;
      r_acc_ok    <= 1'b0;
      r_req_vld   <= 1'b0;
      r_cmd_vld   <= 1'b0;
      r_cmd_dat   <= '0;
      r_cur_addr  <= '0;
      r_rem       <= '0;
      r_btt       <= '0;
      r_tag       <= '0;
      r_err_vld   <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_err_vld  <= 1'b0;
      r_err_code <= 2'd0;
      case (r_state)
        S_IDLE: begin
          if (s_rdma_req_valid_i) begin
            r_vaddr <= s_rdma_req_vaddr_i;
            r_len   <= s_rdma_req_len_i;
            // zero-length requests are swallowed without touching the cache
            if (s_rdma_req_len_i == '0) begin
              r_state <= S_IDLE;
            end else if (s_rdma_req_ctl_i) begin
              r_base      <= s_rdma_req_vaddr_i;
              r_cache_vld <= 1'b0;
              r_req_vld   <= 1'b1;
              r_state     <= S_LOOKUP;
            end else if (r_cache_vld) begin
              r_state <= S_CHECK;
            end else begin
              r_err_vld  <= 1'b1;
              r_err_code <= 2'd1;
            end
          end
        end
        S_LOOKUP: begin
          if (req_addr_ready_i) begin
            r_req_vld <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_addr_valid_i) begin
            r_paddr     <= resp_addr_data_i[ADDR_W-1:0];
            r_buflen    <= resp_addr_data_i[ADDR_W +: 48];
            r_acc_ok    <= resp_addr_data_i[ACC_BIT];
            r_cache_vld <= 1'b1;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!r_acc_ok) begin
            r_err_vld  <= 1'b1;
            r_err_code <= 2'd3;
            r_state    <= S_IDLE;
          end else if (w_bounds_bad) begin
            r_err_vld  <= 1'b1;
            r_err_code <= 2'd2;
            r_state    <= S_IDLE;
          end else begin
            r_cur_addr <= w_first_addr;
            r_rem      <= r_len;
            r_btt      <= f_chunk(r_len);
            r_cmd_dat  <= f_cmd(w_first_addr, f_chunk(r_len), f_last(r_len), r_tag);
            r_cmd_vld  <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (cmd_ready_i) begin
            r_tag      <= r_tag + 4'd1;
            r_cur_addr <= w_next_addr;
            r_rem      <= w_next_rem;
            if (w_next_rem == '0) begin
              r_cmd_vld <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_btt     <= f_chunk(w_next_rem);
              r_cmd_dat <= f_cmd(w_next_addr, f_chunk(w_next_rem), f_last(w_next_rem),
                                 r_tag + 4'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_rdma_req_ready_o = (r_state == S_IDLE);
  assign req_addr_valid_o   = r_req_vld;
  assign req_addr_vaddr_o   = r_base;
  assign resp_addr_ready_o  = (r_state == S_WAIT);
  assign cmd_valid_o        = r_cmd_vld;
  assign cmd_data_o         = r_cmd_dat;
  assign err_valid_o        = r_err_vld;
  assign err_code_o         = r_err_code;
  assign busy_o             = (r_state != S_IDLE);

endmodule

// File: tb/tb_roce_stack_req_translator.sv
// Scoreboarded bench for roce_stack_req_translator with a simple translation responder.
module tb_roce_stack_req_translator;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 28;
  localparam int BTT_W  = 23;
  localparam int CMD_W  = ADDR_W + BTT_W + 17;

  logic clk_i = 1'b0;
  logic aresetn_i = 1'b0;
  logic s_rdma_req_valid_i = 1'b0;
  logic s_rdma_req_ready_o;
  logic [ADDR_W-1:0] s_rdma_req_vaddr_i = '0;
  logic [LEN_W-1:0]  s_rdma_req_len_i = '0;
  logic s_rdma_req_ctl_i = 1'b0;
  logic req_addr_valid_o;
  logic req_addr_ready_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_vaddr_o;
  logic resp_addr_valid_i = 1'b0;
  logic resp_addr_ready_o;
  logic [ADDR_W+51:0] resp_addr_data_i = '0;
  logic cmd_valid_o;
  logic cmd_ready_i = 1'b1;
  logic [CMD_W-1:0] cmd_data_o;
  logic err_valid_o;
  logic [1:0] err_code_o;
  logic busy_o;

  roce_stack_req_translator dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .s_rdma_req_valid_i(s_rdma_req_valid_i), .s_rdma_req_ready_o(s_rdma_req_ready_o),
    .s_rdma_req_vaddr_i(s_rdma_req_vaddr_i), .s_rdma_req_len_i(s_rdma_req_len_i),
    .s_rdma_req_ctl_i(s_rdma_req_ctl_i),
    .req_addr_valid_o(req_addr_valid_o), .req_addr_ready_i(req_addr_ready_i),
    .req_addr_vaddr_o(req_addr_vaddr_o),
    .resp_addr_valid_i(resp_addr_valid_i), .resp_addr_ready_o(resp_addr_ready_o),
    .resp_addr_data_i(resp_addr_data_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_data_o(cmd_data_o),
    .err_valid_o(err_valid_o), .err_code_o(err_code_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [CMD_W-1:0]  exp_cmd_q[$];
  logic [1:0]        exp_err_q[$];
  logic [ADDR_W-1:0] exp_lkp_q[$];

  logic [ADDR_W-1:0] tr_paddr  = '0;
  logic [47:0]       tr_buflen = '0;
  logic [3:0]        tr_access = '0;
  logic              prev_err  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    total++;
    bad++;
    $display("FAIL %s act=%h exp=none", name, act);
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [63:0] a, input logic [22:0] b,
                                               input logic eof, input logic [3:0] tag);
    return {4'b0, tag, a, 1'b0, eof, 6'b0, 1'b1, b};
  endfunction

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (aresetn_i) begin
      if (cmd_valid_o && cmd_ready_i) begin
        if (exp_cmd_q.size() == 0) fail("cmd_unexpected", cmd_data_o);
        else chk("cmd", cmd_data_o, exp_cmd_q.pop_front());
      end
      if (err_valid_o) begin
        chk("err_single_cycle", prev_err, 1'b0);
        if (!prev_err) begin
          if (exp_err_q.size() == 0) fail("err_unexpected", err_code_o);
          else chk("err_code", err_code_o, exp_err_q.pop_front());
        end
      end
      if (req_addr_valid_o && req_addr_ready_i) begin
        if (exp_lkp_q.size() == 0) fail("lookup_unexpected", req_addr_vaddr_o);
        else chk("lookup_vaddr", req_addr_vaddr_o, exp_lkp_q.pop_front());
      end
    end
    prev_err = err_valid_o;
  end

  // translation responder
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!aresetn_i) begin
        phase = 0; req_addr_ready_i = 1'b0; resp_addr_valid_i = 1'b0;
      end else if (phase == 0) begin
        if (req_addr_valid_o) begin req_addr_ready_i = 1'b1; phase = 1; end
      end else if (phase == 1) begin
        req_addr_ready_i  = 1'b0;
        resp_addr_valid_i = 1'b1;
        resp_addr_data_i  = {tr_access, tr_buflen, tr_paddr};
        phase = 2;
      end else begin
        resp_addr_valid_i = 1'b0;
        phase = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_req(input logic [63:0] va, input logic [27:0] ln, input logic ct);
    int n = 0;
    while (!s_rdma_req_ready_o && n < 500) begin step(1); n++; end
    if (n >= 500) fail("req_ready_timeout", busy_o);
    s_rdma_req_valid_i = 1'b1;
    s_rdma_req_vaddr_i = va;
    s_rdma_req_len_i   = ln;
    s_rdma_req_ctl_i   = ct;
    step(1);
    s_rdma_req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    step(1);
    while (busy_o && n < 500) begin step(1); n++; end
    if (n >= 500) fail("idle_timeout", busy_o);
    step(3);
  endtask

  task automatic wait_cmd_valid();
    int n = 0;
    while (!cmd_valid_o && n < 200) begin step(1); n++; end
    if (n >= 200) fail("cmd_valid_timeout", cmd_valid_o);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_rdy"},  s_rdma_req_ready_o, 1'b1);
    chk({tag, "_lkp_vld"},  req_addr_valid_o, 1'b0);
    chk({tag, "_resp_rdy"}, resp_addr_ready_o, 1'b0);
    chk({tag, "_cmd_vld"},  cmd_valid_o, 1'b0);
    chk({tag, "_cmd_dat"},  cmd_data_o, '0);
    chk({tag, "_err_vld"},  err_valid_o, 1'b0);
    chk({tag, "_busy"},     busy_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #12;
    chk_reset_outputs("rst");
    step(1);
    aresetn_i = 1'b1;
    step(2);

    // ctl=0 straight out of reset: cache invalid
    exp_err_q.push_back(2'd1);
    send_req(64'h1000, 28'h100, 1'b0);
    chk("nocache_no_lookup", req_addr_valid_o, 1'b0);
    wait_idle();

    // first request of a message, via translation
    tr_paddr = 64'h8000_0000; tr_buflen = 48'h1000; tr_access = 4'b0001;
    exp_lkp_q.push_back(64'h1000);
    exp_cmd_q.push_back(mk_cmd(64'h8000_0000, 23'h100, 1'b1, 4'd0));
    send_req(64'h1000, 28'h100, 1'b1);
    chk("lookup_at_n1", req_addr_valid_o, 1'b1);
    wait_idle();

    // cached follow-up, two-cycle latency
    exp_cmd_q.push_back(mk_cmd(64'h8000_0200, 23'h80, 1'b1, 4'd1));
    send_req(64'h1200, 28'h80, 1'b0);
    chk("cached_n1_novld", cmd_valid_o, 1'b0);
    chk("cached_no_lookup", req_addr_valid_o, 1'b0);
    step(1);
    chk("cached_n2_vld", cmd_valid_o, 1'b1);
    wait_idle();

    // bounds: offset 0xF80 + 0x100 > 0x1000
    exp_err_q.push_back(2'd2);
    send_req(64'h1F80, 28'h100, 1'b0);
    wait_idle();

    // three-chunk split with a mid-sequence stall
    tr_paddr = 64'h1_0000_0000; tr_buflen = 48'h10_0000; tr_access = 4'b0001;
    exp_lkp_q.push_back(64'h2000_0000);
    exp_cmd_q.push_back(mk_cmd(64'h1_0000_0000, 23'h10000, 1'b0, 4'd2));
    exp_cmd_q.push_back(mk_cmd(64'h1_0001_0000, 23'h10000, 1'b0, 4'd3));
    exp_cmd_q.push_back(mk_cmd(64'h1_0002_0000, 23'h08000, 1'b1, 4'd4));
    cmd_ready_i = 1'b0;
    send_req(64'h2000_0000, 28'h28000, 1'b1);
    wait_cmd_valid();
    cmd_ready_i = 1'b1;
    step(1);
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_vld", cmd_valid_o, 1'b1);
      chk("stall_dat", cmd_data_o, mk_cmd(64'h1_0001_0000, 23'h10000, 1'b0, 4'd3));
      step(1);
    end
    cmd_ready_i = 1'b1;
    wait_idle();

    // access denied wins over bounds
    tr_paddr = 64'h9000; tr_buflen = 48'h1000; tr_access = 4'b0010;
    exp_lkp_q.push_back(64'h3000);
    exp_err_q.push_back(2'd3);
    send_req(64'h3000, 28'h2000, 1'b1);
    wait_idle();

    // reset in the middle of a split
    tr_paddr = 64'h5000_0000; tr_buflen = 48'h10_0000; tr_access = 4'b0001;
    exp_lkp_q.push_back(64'h0);
    exp_cmd_q.push_back(mk_cmd(64'h5000_0000, 23'h10000, 1'b0, 4'd5));
    cmd_ready_i = 1'b0;
    send_req(64'h0, 28'h30000, 1'b1);
    wait_cmd_valid();
    cmd_ready_i = 1'b1;
    step(1);
    cmd_ready_i = 1'b0;
    aresetn_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step(1);
    aresetn_i = 1'b1;
    cmd_ready_i = 1'b1;
    step(2);
    exp_err_q.push_back(2'd1);
    send_req(64'h10, 28'h10, 1'b0);
    wait_idle();

    // tag restarts at 0, then 20 cached requests wrap it
    tr_paddr = 64'h6000_0000; tr_buflen = 48'h10000; tr_access = 4'b0001;
    exp_lkp_q.push_back(64'h7000);
    exp_cmd_q.push_back(mk_cmd(64'h6000_0000, 23'h40, 1'b1, 4'd0));
    send_req(64'h7000, 28'h40, 1'b1);
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      logic [3:0] t;
      t = 4'(i + 1);
      exp_cmd_q.push_back(mk_cmd(64'h6000_0000 + 64'(i * 16), 23'h10, 1'b1, t));
      send_req(64'h7000 + 64'(i * 16), 28'h10, 1'b0);
      wait_idle();
    end

    // zero length: silently consumed
    send_req(64'h7000, 28'h0, 1'b0);
    chk("len0_ready", s_rdma_req_ready_o, 1'b1);
    chk("len0_busy", busy_o, 1'b0);
    step(5);

    chk("drain_cmd", 32'(exp_cmd_q.size()), 32'd0);
    chk("drain_err", 32'(exp_err_q.size()), 32'd0);
    chk("drain_lookup", 32'(exp_lkp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/roce_stack_req_translator.md
Name: roce_stack_req_translator

Overview:
- Parametrised successor of the RoCE request-to-datamover handler.
- Accepts RDMA read/write requests carrying a virtual address, and resolves the physical address through the address-translation interface or a one-entry translation cache.
- Checks access rights and buffer bounds, splits long transfers into bounded datamover commands with rolling tags, and reports rejected requests on an error strobe.
- Sits between the RoCE stack request port and the AXI datamover command port.

Parameters:
- READ, 1'b1: 1 = read channel (requires access bit 0); 0 = write channel (requires access bit 1).
- ADDR_W, 64: virtual/physical address width.
- LEN_W, 28: request length width (bytes).
- BTT_W, 23: datamover bytes-to-transfer field width.
- MAX_CHUNK, 65536: maximum bytes per datamover command; must be ≥1 and ≤2^BTT_W-1.
- CMD_W, ADDR_W+BTT_W+17: command word width (derived, do not override).

Ports:
- clk_i, in, 1: clock.
- aresetn_i, in, 1: reset, asynchronous, active-low.
- s_rdma_req_valid_i / s_rdma_req_ready_o, in/out, 1: request handshake.
- s_rdma_req_vaddr_i, in, ADDR_W: request virtual address.
- s_rdma_req_len_i, in, LEN_W: request length in bytes.
- s_rdma_req_ctl_i, in, 1: 1 = first request of a message (forces a lookup).
- req_addr_valid_o / req_addr_ready_i, out/in, 1: translation request handshake.
- req_addr_vaddr_o, out, ADDR_W: vaddr to translate.
- resp_addr_valid_i / resp_addr_ready_o, in/out, 1: translation response handshake.
- resp_addr_data_i, in, ADDR_W+52: {access[3:0], buflen[47:0], paddr[ADDR_W-1:0]}.
- cmd_valid_o / cmd_ready_i, out/in, 1: datamover command handshake.
- cmd_data_o, out, CMD_W: {4'b0, tag[3:0], addr, 1'b0 drr, eof, 6'b0 dsa, 1'b1 incr, btt[BTT_W-1:0]}.
- err_valid_o, out, 1: one-cycle strobe marking a rejected request.
- err_code_o, out, 2: error code, valid with err_valid_o; 1 = no translation, 2 = bounds, 3 = access denied.
- busy_o, out, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset values: all outputs 0, except s_rdma_req_ready_o = 1. State IDLE, cache invalid, tag = 0, internal registers 0.
- Reset is asynchronous and may assert mid-operation. It aborts any command or lookup in flight, and nothing is replayed afterwards.

IDLE state:
- s_rdma_req_ready_o = 1 only in IDLE; every other output handshake is idle.
- A request is accepted on valid&ready, and vaddr, len and ctl are latched.
- ctl = 1: base := vaddr, go to LOOKUP.
- ctl = 0 with cache valid: go to CHECK.
- ctl = 0 with cache invalid: pulse err code 1 next cycle, return to IDLE.
- len == 0: consumed silently (no command, no error), stays in IDLE.

LOOKUP state:
- req_addr_valid_o = 1 and req_addr_vaddr_o = base, held stable until req_addr_ready_i.
- The cycle after the request handshake, go to WAIT.

WAIT state:
- resp_addr_ready_o = 1.
- On resp_addr_valid_i: load paddr/buflen/access into the cache, set cache valid, go to CHECK.
- resp_addr_ready_o is 0 in every other state.

CHECK state (one cycle):
- offset = vaddr - base, computed ADDR_W wide.
- Access check fails if access[READ?0:1] == 0.
- Bounds check fails if vaddr < base, or {offset} + len > buflen, computed with zero-extension to max(ADDR_W,48)+1 bits (no overflow).
- Priority: access denied (3) before bounds (2).
- On error: err_valid_o = 1 for exactly one cycle, return to IDLE. The cache is retained.
- Otherwise: cur_addr := paddr + offset, remaining := len, go to SEND.

SEND state:
- chunk = min(remaining, MAX_CHUNK).
- cmd_data_o fields: addr = cur_addr, btt = chunk, eof = (remaining == chunk), tag = tag counter.
- cmd_valid_o and cmd_data_o come from registers and stay stable until cmd_ready_i.
- On handshake: tag increments (wraps 15→0), cur_addr += chunk, remaining -= chunk. If remaining becomes 0, go to IDLE; else present the next chunk in the following cycle.

Latency:
- Cached path: accept at cycle N, first cmd_valid_o at N+2.
- Lookup path: req_addr_valid_o at N+1.
- Back-to-back command chunks: one per cycle when cmd_ready_i is held high.

Cache invalidation: ctl = 1 invalidates the old entry at acceptance. A subsequent error in CHECK does not re-invalidate it.

Test Plan:
- READ=1, ctl=1, vaddr=0x1000, len=0x100. Translation returns paddr=0x8000_0000, buflen=0x1000, access=4'b0001. Required: one command, addr 0x8000_0000, btt 0x100, eof=1, tag 0.
- Follow-up with ctl=0, vaddr=0x1200, len=0x80. Required: no lookup; command addr 0x8000_0200, btt 0x80, tag 1, issued 2 cycles after accept.
- MAX_CHUNK=65536, len=0x28000 within the buffer. Required: three commands with btt 0x10000, 0x10000, 0x8000; addresses advancing by 0x10000; eof only on the third; tags consecutive. Hold cmd_ready_i low for 3 cycles mid-sequence and verify data stays stable.
- Error cases:
  - ctl=0 immediately after reset → err_code 1, no lookup, no command.
  - offset 0xF80 with len 0x100 against buflen 0x1000 → err_code 2.
  - READ=1 with access=4'b0010 → err_code 3.
  - In every case err_valid_o is high for exactly one cycle.
- Assert aresetn_i low mid-split (after the first chunk) and release. Required: all outputs return to reset values; a ctl=0 request then yields err_code 1 (cache invalid); the tag restarts at 0.
- 20 consecutive requests → tag wraps 15→0. len=0 → no command, no error, s_rdma_req_ready_o stays 1.
